// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full / almost-full / level flags and sticky overflow.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic                  ovf_clr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr_gray;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wlevel;
    logic          r_wovf;

    logic          w_push;
    logic          w_ovf_evt;
    logic [PW-1:0] w_wq2_rptr;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_full_cmp;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;
    logic          w_afull_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int s = 1; s < int'(PW); s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    // Read-pointer synchroniser; nothing else samples rptr_gray
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= rptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_wq2_rptr = r_sync[SYNC_STAGES-1];
    assign w_rbin     = gray2bin(w_wq2_rptr);

    assign w_push       = winc & ~r_wfull;
    assign w_ovf_evt    = winc & r_wfull;
    assign w_wbin_next  = r_wbin + PW'(w_push);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Full when the write pointer is one lap ahead of the synchronised read pointer
    assign w_full_cmp   = {~w_wq2_rptr[PW-1:PW-2], w_wq2_rptr[PW-3:0]};
    assign w_full_next  = (w_wgray_next == w_full_cmp);
    assign w_level_next = w_wbin_next - w_rbin;
    assign w_afull_next = (w_level_next >= PW'(AFULL_LEVEL));

    // Pointer and flag registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr_gray    <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr_gray    <= w_wgray_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= w_afull_next;
            r_wlevel       <= w_level_next;
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_wovf <= 1'b1;
        end else if (ovf_clr) begin
            r_wovf <= 1'b0;
        end
    end

    assign wen          = w_push;
    assign waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign wptr_gray    = r_wptr_gray;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign wovf         = r_wovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl with default parameters.
module tb_fifo_wr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr_gray;
    logic       ovf_clr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int unsigned total = 0;
    int unsigned bad   = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .AFULL_LEVEL (12)
    ) u_dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .ovf_clr      (ovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wen"},   32'(wen),          32'd0);
        check({tag, ".waddr"}, 32'(waddr),        32'd0);
        check({tag, ".wgray"}, 32'(wptr_gray),    32'd0);
        check({tag, ".wfull"}, 32'(wfull),        32'd0);
        check({tag, ".afull"}, 32'(walmost_full), 32'd0);
        check({tag, ".wlvl"},  32'(wlevel),       32'd0);
        check({tag, ".wovf"},  32'(wovf),         32'd0);
    endtask

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] mb;
        logic [4:0] prev_g;

        wrst_n    = 1'b0;
        winc      = 1'b0;
        rptr_gray = 5'd0;
        ovf_clr   = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        wrst_n = 1'b1;

        // Fill 16 entries against a stationary read pointer
        for (int k = 0; k < 16; k++) begin
            winc = 1'b1;
            #1;
            check("fill.wen",   32'(wen),   32'd1);
            check("fill.waddr", 32'(waddr), 32'(k));
            tick();
            check("fill.wlvl",  32'(wlevel),       32'(k + 1));
            check("fill.afull", 32'(walmost_full), 32'(k + 1 >= 12));
            check("fill.wfull", 32'(wfull),        32'(k == 15));
        end
        check("fill.wgray", 32'(wptr_gray), 32'h18);

        // Writes while full are dropped and set the sticky flag
        for (int k = 0; k < 3; k++) begin
            winc = 1'b1;
            #1;
            check("ovf.wen", 32'(wen), 32'd0);
            tick();
            check("ovf.wgray", 32'(wptr_gray), 32'h18);
            check("ovf.wlvl",  32'(wlevel),    32'd16);
            check("ovf.wovf",  32'(wovf),      32'd1);
        end
        winc    = 1'b0;
        ovf_clr = 1'b1;
        tick();
        check("ovfclr.wovf", 32'(wovf), 32'd0);

        // Overflow and clear together: set wins
        winc = 1'b1;
        tick();
        check("ovfboth.wovf", 32'(wovf), 32'd1);
        winc = 1'b0;
        tick();
        check("ovfclr2.wovf", 32'(wovf), 32'd0);
        ovf_clr = 1'b0;

        // One read becomes visible after two sync flops plus the flag register
        rptr_gray = 5'b00001;
        tick();
        check("rel1.wfull", 32'(wfull), 32'd1);
        tick();
        check("rel2.wfull", 32'(wfull), 32'd1);
        tick();
        check("rel3.wfull", 32'(wfull),  32'd0);
        check("rel3.wlvl",  32'(wlevel), 32'd15);

        // Asynchronous reset mid-burst
        wrst_n    = 1'b0;
        rptr_gray = 5'd0;
        #1;
        check_all_zero("rst2");
        tick();
        wrst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            winc = 1'b1;
            tick();
        end
        check("burst.wlvl", 32'(wlevel), 32'd7);
        #2;
        wrst_n = 1'b0;
        winc   = 1'b0;
        #1;
        check_all_zero("rstmid");
        #3;
        wrst_n = 1'b1;
        tick();
        winc = 1'b1;
        #1;
        check("post.wen",   32'(wen),   32'd1);
        check("post.waddr", 32'(waddr), 32'd0);
        tick();
        check("post.wlvl", 32'(wlevel), 32'd1);
        winc = 1'b0;

        // Stream 40 writes with the reader one push behind, across the pointer wrap
        wrst_n    = 1'b0;
        rptr_gray = 5'd0;
        #1;
        wrst_n = 1'b1;
        tick();
        mb     = 5'd0;
        prev_g = 5'd0;
        for (int k = 0; k < 40; k++) begin
            winc = 1'b1;
            #1;
            check("strm.wen",   32'(wen),   32'd1);
            check("strm.waddr", 32'(waddr), 32'(mb[3:0]));
            tick();
            mb = mb + 5'd1;
            check("strm.wgray", 32'(wptr_gray), 32'(gray5(mb)));
            check("strm.1bit",  32'($countones(wptr_gray ^ prev_g)), 32'd1);
            check("strm.wfull", 32'(wfull), 32'd0);
            prev_g    = wptr_gray;
            rptr_gray = gray5(mb - 5'd1);
        end
        winc = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
